// File: rtl/l2_input_scheduler.sv
// l2_input_scheduler: priority scheduler for L2 inputs (flush sweep, responses, forwards, cpu requests)
// Ports: clk/rst (async, active-low); decode_en gates every selection.
//   flush/rsp/fwd/cpu request inputs with ready and from_* handshakes (combinational).
//   do_*, sel_tag, sel_set, sweep_way, flush_done are registered one cycle after selection.
//   idle flags a decode cycle with nothing selected; sweep_busy is high while a flush is in progress.
module l2_input_scheduler #(
  parameter int N_REQS = 4,
  parameter int L2_SETS = 256,
  parameter int L2_WAYS = 8,
  parameter int LINE_W = 26,
  parameter int STARVE_MAX = 15,
  localparam int SB = $clog2(L2_SETS),
  localparam int WB = $clog2(L2_WAYS),
  localparam int TW = LINE_W - SB,
  localparam int CW = $clog2(N_REQS) + 1
)(
  input  logic clk,
  input  logic rst,
  input  logic decode_en,
  input  logic flush_valid,
  output logic flush_ready,
  input  logic rsp_valid,
  output logic rsp_ready,
  input  logic [LINE_W-1:0] rsp_addr,
  input  logic fwd_valid,
  output logic fwd_ready,
  input  logic fwd_stall,
  input  logic fwd_stall_ended,
  input  logic [LINE_W-1:0] fwd_addr,
  output logic fwd_from_stalled,
  input  logic cpu_valid,
  output logic cpu_ready,
  input  logic [LINE_W-1:0] cpu_addr,
  input  logic set_conflict,
  output logic cpu_from_conflict,
  input  logic evict_stall,
  input  logic ongoing_atomic,
  input  logic [CW-1:0] reqs_cnt,
  output logic do_flush,
  output logic do_rsp,
  output logic do_fwd,
  output logic do_sweep,
  output logic do_cpu,
  output logic [TW-1:0] sel_tag,
  output logic [SB-1:0] sel_set,
  output logic [WB-1:0] sweep_way,
  output logic flush_done,
  output logic idle,
  output logic sweep_busy
);
  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;
  state_t state, state_d;
  logic [SB-1:0] flush_set, set_d, sel_set_d;
  logic [WB-1:0] flush_way, way_d, sweep_way_d;
  logic [TW-1:0] sel_tag_d;
  logic [7:0] starve_cnt, starve_d;
  logic [4:0] do_q, do_d;
  logic done_d, full, cpu_elig, cpu_sel;
  assign full = reqs_cnt == CW'(N_REQS);
  assign cpu_elig = (cpu_valid || set_conflict) && !evict_stall && (reqs_cnt != '0 || ongoing_atomic);
  assign sweep_busy = state != IDLE;
  assign {do_flush, do_rsp, do_fwd, do_sweep, do_cpu} = do_q;
  always_comb begin
    flush_ready = 1'b0;
    rsp_ready = 1'b0;
    fwd_ready = 1'b0;
    fwd_from_stalled = 1'b0;
    cpu_ready = 1'b0;
    cpu_from_conflict = 1'b0;
    idle = 1'b0;
    cpu_sel = 1'b0;
    do_d = '0;
    sel_tag_d = '0;
    sel_set_d = '0;
    sweep_way_d = '0;
    done_d = 1'b0;
    state_d = state;
    set_d = flush_set;
    way_d = flush_way;
    if (decode_en) begin
      if (flush_valid && full && state == IDLE) begin
        flush_ready = 1'b1;
        do_d = 5'b10000;
        state_d = SWEEP;
        set_d = '0;
        way_d = '0;
      end else if (rsp_valid && !full) begin
        rsp_ready = 1'b1;
        do_d = 5'b01000;
        {sel_tag_d, sel_set_d} = rsp_addr;
      end else if (cpu_elig && starve_cnt == 8'(STARVE_MAX)) begin
        cpu_sel = 1'b1;
      end else if ((fwd_valid && !fwd_stall) || fwd_stall_ended) begin
        fwd_ready = fwd_valid && !fwd_stall;
        fwd_from_stalled = !(fwd_valid && !fwd_stall);
        do_d = 5'b00100;
        {sel_tag_d, sel_set_d} = fwd_addr;
      end else if (state == DONE) begin
        done_d = 1'b1;
        state_d = IDLE;
        set_d = '0;
        way_d = '0;
      end else if (state == SWEEP) begin
        if (!fwd_valid && reqs_cnt != '0) begin
          do_d = 5'b00010;
          sel_set_d = flush_set;
          sweep_way_d = flush_way;
          way_d = flush_way + 1'b1;
          set_d = flush_way == WB'(L2_WAYS - 1) ? flush_set + 1'b1 : flush_set;
          state_d = flush_way == WB'(L2_WAYS - 1) && flush_set == SB'(L2_SETS - 1) ? DONE : SWEEP;
        end
      end else if (cpu_elig) begin
        cpu_sel = 1'b1;
      end else begin
        idle = 1'b1;
      end
      if (cpu_sel) begin
        cpu_ready = !set_conflict;
        cpu_from_conflict = set_conflict;
        do_d = 5'b00001;
        {sel_tag_d, sel_set_d} = cpu_addr;
      end
    end
    starve_d = cpu_elig && !cpu_sel ? (starve_cnt == 8'(STARVE_MAX) ? starve_cnt : starve_cnt + 8'd1) : 8'd0;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      flush_set <= '0;
      flush_way <= '0;
      starve_cnt <= '0;
      do_q <= '0;
      sel_tag <= '0;
      sel_set <= '0;
      sweep_way <= '0;
      flush_done <= 1'b0;
    end else if (decode_en) begin
      state <= state_d;
      flush_set <= set_d;
      flush_way <= way_d;
      starve_cnt <= starve_d;
      do_q <= do_d;
      sel_tag <= sel_tag_d;
      sel_set <= sel_set_d;
      sweep_way <= sweep_way_d;
      flush_done <= done_d;
    end
  end
endmodule

// File: tb/tb_l2_input_scheduler.sv
// tb_l2_input_scheduler: directed vector table plus multi-cycle sequences for l2_input_scheduler
module tb_l2_input_scheduler;
  logic clk = 1'b0, rst = 1'b0;
  logic decode_en, flush_valid, rsp_valid, fwd_valid, fwd_stall, fwd_stall_ended;
  logic cpu_valid, set_conflict, evict_stall, ongoing_atomic;
  logic [2:0] reqs_cnt;
  logic [25:0] rsp_addr, fwd_addr, cpu_addr;
  logic flush_ready, rsp_ready, fwd_ready, fwd_from_stalled, cpu_ready, cpu_from_conflict;
  logic do_flush, do_rsp, do_fwd, do_sweep, do_cpu, flush_done, idle, sweep_busy;
  logic [17:0] sel_tag;
  logic [7:0] sel_set;
  logic [2:0] sweep_way;
  int checks = 0, failures = 0;

  l2_input_scheduler dut (
    .clk(clk), .rst(rst), .decode_en(decode_en),
    .flush_valid(flush_valid), .flush_ready(flush_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_addr(rsp_addr),
    .fwd_valid(fwd_valid), .fwd_ready(fwd_ready), .fwd_stall(fwd_stall),
    .fwd_stall_ended(fwd_stall_ended), .fwd_addr(fwd_addr), .fwd_from_stalled(fwd_from_stalled),
    .cpu_valid(cpu_valid), .cpu_ready(cpu_ready), .cpu_addr(cpu_addr),
    .set_conflict(set_conflict), .cpu_from_conflict(cpu_from_conflict),
    .evict_stall(evict_stall), .ongoing_atomic(ongoing_atomic), .reqs_cnt(reqs_cnt),
    .do_flush(do_flush), .do_rsp(do_rsp), .do_fwd(do_fwd), .do_sweep(do_sweep), .do_cpu(do_cpu),
    .sel_tag(sel_tag), .sel_set(sel_set), .sweep_way(sweep_way),
    .flush_done(flush_done), .idle(idle), .sweep_busy(sweep_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] in;
    logic [2:0] cnt;
    logic [6:0] rdy;
    logic [4:0] dv;
    logic [7:0] st;
    logic [17:0] tg;
  } vec_t;
  vec_t vt[16];

  function automatic logic [6:0] rdy_now();
    return {flush_ready, rsp_ready, fwd_ready, fwd_from_stalled, cpu_ready, cpu_from_conflict, idle};
  endfunction
  function automatic logic [4:0] dv_now();
    return {do_flush, do_rsp, do_fwd, do_sweep, do_cpu};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [9:0] in, input logic [2:0] cnt);
    {decode_en, flush_valid, rsp_valid, fwd_valid, fwd_stall, fwd_stall_ended,
     cpu_valid, set_conflict, evict_stall, ongoing_atomic} = in;
    reqs_cnt = cnt;
  endtask

  task automatic clr();
    drive(10'h200, 3'd2);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, bad, fr_bad, done_n, cyc, stray;
    rsp_addr = 26'h2AAAA11;
    fwd_addr = 26'h1555522;
    cpu_addr = 26'h0F0F033;
    vt[0]  = '{10'h200, 3'd2, 7'b0000001, 5'b00000, 8'h00, 18'h00000};
    vt[1]  = '{10'h080, 3'd2, 7'b0000000, 5'b00000, 8'h00, 18'h00000};
    vt[2]  = '{10'h2C0, 3'd3, 7'b0100000, 5'b01000, 8'h11, 18'h2AAAA};
    vt[3]  = '{10'h280, 3'd4, 7'b0000001, 5'b00000, 8'h00, 18'h00000};
    vt[4]  = '{10'h240, 3'd2, 7'b0010000, 5'b00100, 8'h22, 18'h15555};
    vt[5]  = '{10'h260, 3'd2, 7'b0000001, 5'b00000, 8'h00, 18'h00000};
    vt[6]  = '{10'h270, 3'd2, 7'b0001000, 5'b00100, 8'h22, 18'h15555};
    vt[7]  = '{10'h208, 3'd2, 7'b0000100, 5'b00001, 8'h33, 18'h0F0F0};
    vt[8]  = '{10'h204, 3'd2, 7'b0000010, 5'b00001, 8'h33, 18'h0F0F0};
    vt[9]  = '{10'h20A, 3'd2, 7'b0000001, 5'b00000, 8'h00, 18'h00000};
    vt[10] = '{10'h208, 3'd0, 7'b0000001, 5'b00000, 8'h00, 18'h00000};
    vt[11] = '{10'h209, 3'd0, 7'b0000100, 5'b00001, 8'h33, 18'h0F0F0};
    vt[12] = '{10'h248, 3'd2, 7'b0010000, 5'b00100, 8'h22, 18'h15555};
    vt[13] = '{10'h288, 3'd1, 7'b0100000, 5'b01000, 8'h11, 18'h2AAAA};
    vt[14] = '{10'h300, 3'd3, 7'b0000001, 5'b00000, 8'h00, 18'h00000};
    vt[15] = '{10'h210, 3'd2, 7'b0001000, 5'b00100, 8'h22, 18'h15555};

    clr();
    repeat (2) @(negedge clk);
    #1;
    chk("reset_do", 32'(dv_now()), 0);
    chk("reset_sel", {sel_tag, sel_set, sweep_way, flush_done, sweep_busy}, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      drive(vt[i].in, vt[i].cnt);
      #1;
      chk($sformatf("vec%0d_ready", i), 32'(rdy_now()), 32'(vt[i].rdy));
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_do", i), 32'(dv_now()), 32'(vt[i].dv));
      chk($sformatf("vec%0d_sel", i), {6'd0, sel_tag, sel_set}, {6'd0, vt[i].tg, vt[i].st});
      @(negedge clk);
      clr();
      @(posedge clk);
    end

    @(negedge clk);
    drive(10'h248, 3'd2);
    for (int i = 1; i <= 20; i++) begin
      #1;
      chk($sformatf("starve_c%0d", i), {cpu_ready, fwd_ready}, i == 16 ? 2'b10 : 2'b01);
      @(negedge clk);
    end
    clr();

    @(negedge clk);
    drive(10'h208, 3'd2);
    @(posedge clk);
    #1;
    chk("hold_do_cpu0", 32'(dv_now()), 5'b00001);
    for (int i = 1; i <= 2; i++) begin
      @(negedge clk);
      drive(10'h0C8, 3'd2);
      #1;
      chk($sformatf("hold_ready%0d", i), 32'(rdy_now()), 0);
      @(posedge clk);
      #1;
      chk($sformatf("hold_do_cpu%0d", i), 32'(dv_now()), 5'b00001);
    end
    @(negedge clk);
    clr();

    @(negedge clk);
    drive(10'h300, 3'd4);
    #1;
    chk("flush_ready", 32'(flush_ready), 1);
    @(posedge clk);
    #1;
    chk("flush_start", {27'd0, dv_now()} | 32'(sweep_busy) << 8, 32'h110);
    k = 0; bad = 0; fr_bad = 0; done_n = 0; cyc = 0;
    while (done_n == 0 && cyc < 2200) begin
      @(posedge clk);
      #1;
      cyc++;
      if (do_sweep) begin
        if (sel_set != k[10:3] || sweep_way != k[2:0]) bad++;
        k++;
        if (k == 2048) flush_valid = 1'b0;
      end
      if (flush_done) done_n++;
      if (sweep_busy && flush_ready) fr_bad++;
    end
    chk("sweep_pulses", k, 2048);
    chk("sweep_order_errs", bad, 0);
    chk("sweep_flush_ready", fr_bad, 0);
    chk("flush_done_seen", done_n, 1);
    chk("done_busy", 32'(sweep_busy), 0);
    @(posedge clk);
    #1;
    chk("done_pulse_end", {flush_done, dv_now()}, 0);

    @(negedge clk);
    drive(10'h300, 3'd4);
    @(posedge clk);
    @(negedge clk);
    flush_valid = 1'b0;
    repeat (43) @(posedge clk);
    #1;
    chk("mid_5_2", {do_sweep, sel_set, sweep_way}, {1'b1, 8'd5, 3'd2});
    @(negedge clk);
    fwd_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("mid_fwd%0d", i), {dv_now(), sel_set}, {5'b00100, 8'h22});
    end
    @(negedge clk);
    fwd_stall = 1'b1;
    #1;
    chk("stall_noissue_ready", 32'(rdy_now()), 0);
    @(posedge clk);
    #1;
    chk("stall_noissue_do", 32'(dv_now()), 0);
    @(negedge clk);
    fwd_valid = 1'b0;
    fwd_stall = 1'b0;
    @(posedge clk);
    #1;
    chk("resume_5_3", {do_sweep, sel_set, sweep_way}, {1'b1, 8'd5, 3'd3});
    repeat (757) @(posedge clk);
    #1;
    chk("mid_100_0", {do_sweep, sel_set, sweep_way}, {1'b1, 8'd100, 3'd0});
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_regs", {dv_now(), sel_set, sweep_way, sweep_busy, flush_done}, 0);
    @(negedge clk);
    rst = 1'b1;
    stray = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (flush_done || do_sweep) stray++;
    end
    chk("midrst_no_done", stray, 0);
    @(negedge clk);
    drive(10'h300, 3'd4);
    @(posedge clk);
    #1;
    chk("restart_flush", 32'(dv_now()), 5'b10000);
    @(negedge clk);
    flush_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("restart_0_0", {do_sweep, sel_set, sweep_way}, {1'b1, 8'd0, 3'd0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
